m_rf_nwnr: RTL and testbench
============================

Name: m_rf_nwnr

Overview:
- Parameterized register file: 2^AW entries of DW bits, NUM_WRITE synchronous write ports, NUM_READ synchronous read ports.
- Each read port has a registered, load-enabled data output that holds its value when not enabled.
- Instruction-MMU TLB storage uses two instances (TLB low and TLB high words), each with NUM_READ=1 and NUM_WRITE=1. Read index is the low VPN bits; write index and data come from MSR TLBL/TLBH writes.

Parameters:
- DW, 32, data width of each entry in bits (>=1).
- AW, 5, address width; depth = 2^AW entries (>=1).
- NUM_READ, 1, number of independent read ports (>=1).
- NUM_WRITE, 1, number of independent write ports (>=1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RE  in  NUM_READ  per-port read enable; bit i enables read port i.
- RADDR  in  NUM_READ*AW  packed read addresses; port i at bits [i*AW +: AW].
- RDATA  out  NUM_READ*DW  packed registered read data; port i at bits [i*DW +: DW].
- WE  in  NUM_WRITE  per-port write enable.
- WADDR  in  NUM_WRITE*AW  packed write addresses; port j at bits [j*AW +: AW].
- WDATA  in  NUM_WRITE*DW  packed write data; port j at bits [j*DW +: DW].

Behaviour:
- Reset:
  - RST high asynchronously clears all RDATA registers and all 2^AW storage entries to 0, independent of CLK.
  - While RST is high, reads and writes are ignored.
  - The first edge after RST deasserts operates normally.
- Write:
  - At a rising edge, for each j with WE[j]=1, the entry at WADDR[j] takes WDATA[j].
  - Written data is visible to reads issued at the next edge or later.
- Read:
  - At a rising edge, for each i with RE[i]=1, RDATA[i] loads the entry at RADDR[i].
  - Latency is 1 cycle: address presented in cycle N, data valid after edge N.
  - With RE[i]=0, RDATA[i] holds its previous value indefinitely, even if the addressed entry is later overwritten.
- Read-during-write to the same address on the same edge returns the old (pre-write) contents; there is no write-to-read bypass.
- Multiple write ports targeting the same address on the same edge: the highest-numbered enabled port wins; lower ports' data is discarded.
- Read ports are fully independent. Any number may read the same or different addresses simultaneously with identical results.
- Addresses cover the full range 0..2^AW-1; there is no out-of-range case and no wrap logic.
- No combinational path from any input to RDATA (outputs are pure registers).
- Simulation-only check: fatal if NUM_READ<1, NUM_WRITE<1, AW<1 or DW<1.

Test Plan:
- Reset, then RE=1 with RADDR=0, 5 and 31 on successive edges -> RDATA=0 each cycle.
- Write 0xDEADBEEF to addr 3 (WE=1); next edge RE=1, RADDR=3 -> RDATA=0xDEADBEEF one cycle later. Then RE=0 and write 0x12345678 to addr 3 -> RDATA stays 0xDEADBEEF.
- Same edge: WE=1, WADDR=7, WDATA=0xA5A5A5A5, RE=1, RADDR=7, old contents 0x11111111 -> RDATA=0x11111111. Re-read next edge -> 0xA5A5A5A5.
- NUM_WRITE=2, both WE=1, WADDR=9, WDATA0=0x1, WDATA1=0x2 -> later read of addr 9 returns 0x2.
- NUM_READ=2: write addr 1=0xAA, addr 2=0xBB; read RADDR0=1, RADDR1=2 on the same edge -> RDATA port0=0xAA, port1=0xBB. With RE=2'b01, only port0 updates.
- Assert RST mid-cycle (between edges) after RDATA=0xDEADBEEF -> RDATA drops to 0 immediately. After release, read addr 3 -> 0 (storage cleared).

Source files
------------

// File: rtl/m_rf_nwnr.sv
// Parameterized multi-port register file with registered, load-enabled read outputs.
// Storage and read registers clear asynchronously on RST; same-edge reads see pre-write data.

module m_rf_nwnr_param_chk #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_READ  = 1,
    parameter int NUM_WRITE = 1
) ();

    generate
        if ((NUM_READ < 1) || (NUM_WRITE < 1) || (AW < 1) || (DW < 1)) begin : g_bad_params
            $fatal(1, "m_rf_nwnr: NUM_READ, NUM_WRITE, AW and DW must all be >= 1");
        end
    endgenerate

endmodule

module m_rf_nwnr #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_READ  = 1,
    parameter int NUM_WRITE = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_READ-1:0]     RE,
    input  logic [NUM_READ*AW-1:0]  RADDR,
    output logic [NUM_READ*DW-1:0]  RDATA,
    input  logic [NUM_WRITE-1:0]    WE,
    input  logic [NUM_WRITE*AW-1:0] WADDR,
    input  logic [NUM_WRITE*DW-1:0] WDATA
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]          mem_r [DEPTH];
    logic [NUM_READ*DW-1:0] rdata_r;

    m_rf_nwnr_param_chk #(
        .DW        (DW),
        .AW        (AW),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE)
    ) u_param_chk ();

    // Storage update: ports applied in ascending order so the highest enabled port wins a collision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {DW{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (WE[j]) begin
                    mem_r[WADDR[j*AW +: AW]] <= WDATA[j*DW +: DW];
                end
            end
        end
    end

    // Read registers: load on enable, otherwise hold regardless of later storage changes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_r <= {(NUM_READ*DW){1'b0}};
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                if (RE[i]) begin
                    rdata_r[i*DW +: DW] <= mem_r[RADDR[i*AW +: AW]];
                end
            end
        end
    end

    assign RDATA = rdata_r;

endmodule

// File: tb/tb_m_rf_nwnr.sv
// Self-checking bench for m_rf_nwnr (two read and two write ports): directed table,
// randomized traffic against an array model, and asynchronous mid-cycle reset.

module tb_m_rf_nwnr;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rd  [NR];

    typedef struct {
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [18];

    m_rf_nwnr #(
        .DW        (DW),
        .AW        (AW),
        .NUM_READ  (NR),
        .NUM_WRITE (NW)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .RE    (re),
        .RADDR (raddr),
        .RDATA (rdata),
        .WE    (we),
        .WADDR (waddr),
        .WDATA (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'd0;
        for (int i = 0; i < NR; i++) ref_rd[i] = 32'd0;
    endtask

    // Reads observe the array as it stood before this edge; writes then apply, later ports last.
    task automatic model_edge();
        for (int i = 0; i < NR; i++)
            if (re[i]) ref_rd[i] = ref_mem[raddr[i*AW +: AW]];
        for (int j = 0; j < NW; j++)
            if (we[j]) ref_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
    endtask

    task automatic drive(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [1:0] w, input logic [4:0] b0, input logic [4:0] b1,
                         input logic [31:0] d0, input logic [31:0] d1);
        re    = r;
        raddr = {a1, a0};
        we    = w;
        waddr = {b1, b0};
        wdata = {d1, d0};
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd0,  5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        32'h0};
        vecs[1]  = '{2'b11, 5'd5,  5'd31, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        32'h0};
        vecs[2]  = '{2'b01, 5'd31, 5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        32'h0};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,  32'h0,        32'h0};
        vecs[4]  = '{2'b01, 5'd3,  5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'hDEADBEEF, 32'h0};
        vecs[5]  = '{2'b00, 5'd3,  5'd0,  2'b01, 5'd3, 5'd0, 32'h12345678, 32'h0,  32'hDEADBEEF, 32'h0};
        vecs[6]  = '{2'b01, 5'd3,  5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h12345678, 32'h0};
        vecs[7]  = '{2'b00, 5'd0,  5'd0,  2'b01, 5'd7, 5'd0, 32'h11111111, 32'h0,  32'h12345678, 32'h0};
        vecs[8]  = '{2'b01, 5'd7,  5'd0,  2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0,  32'h11111111, 32'h0};
        vecs[9]  = '{2'b01, 5'd7,  5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'hA5A5A5A5, 32'h0};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  2'b11, 5'd9, 5'd9, 32'h1,        32'h2,  32'hA5A5A5A5, 32'h0};
        vecs[11] = '{2'b10, 5'd0,  5'd9,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'hA5A5A5A5, 32'h2};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  2'b11, 5'd1, 5'd2, 32'hAA,       32'hBB, 32'hA5A5A5A5, 32'h2};
        vecs[13] = '{2'b11, 5'd1,  5'd2,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'hAA,       32'hBB};
        vecs[14] = '{2'b01, 5'd2,  5'd1,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'hBB,       32'hBB};
        vecs[15] = '{2'b11, 5'd3,  5'd3,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h12345678, 32'h12345678};
        vecs[16] = '{2'b00, 5'd0,  5'd0,  2'b01, 5'd9, 5'd9, 32'h5,        32'h6,  32'h12345678, 32'h12345678};
        vecs[17] = '{2'b01, 5'd9,  5'd0,  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  32'h5,        32'h12345678};

        rst = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rd0", rdata[31:0], 32'h0);
        check("reset_rd1", rdata[63:32], 32'h0);

        for (int v = 0; v < 18; v++) begin
            drive(vecs[v].re, vecs[v].ra0, vecs[v].ra1, vecs[v].we,
                  vecs[v].wa0, vecs[v].wa1, vecs[v].wd0, vecs[v].wd1);
            cycle();
            check($sformatf("vec%0d_rd0", v), rdata[31:0], vecs[v].e0);
            check($sformatf("vec%0d_rd1", v), rdata[63:32], vecs[v].e1);
        end

        // Narrow address range forces frequent read/write and write/write collisions.
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom);
            if (n % 50 == 49) raddr = {5'd31, 5'($urandom)};
            cycle();
            check($sformatf("rand%0d_rd0", n), rdata[31:0], ref_rd[0]);
            check($sformatf("rand%0d_rd1", n), rdata[63:32], ref_rd[1]);
        end

        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0);
        cycle();
        drive(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        cycle();
        check("pre_rst_rd0", rdata[31:0], 32'hDEADBEEF);
        check("pre_rst_rd1", rdata[63:32], 32'hDEADBEEF);

        // Reset lands between edges; outputs must clear without waiting for a clock.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd0", rdata[31:0], 32'h0);
        check("async_rst_rd1", rdata[63:32], 32'h0);
        model_reset();
        drive(2'b11, 5'd3, 5'd3, 2'b11, 5'd3, 5'd4, 32'hCAFEF00D, 32'h77777777);
        @(negedge clk);
        @(negedge clk);
        check("rst_held_rd0", rdata[31:0], 32'h0);
        rst = 1'b0;
        drive(2'b11, 5'd3, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        cycle();
        check("post_rst_addr3", rdata[31:0], 32'h0);
        check("post_rst_addr4", rdata[63:32], 32'h0);
        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd12, 32'h0, 32'h600DD00D);
        cycle();
        drive(2'b01, 5'd12, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        cycle();
        check("post_rst_first_write", rdata[31:0], 32'h600DD00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
